// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one data-memory transaction per request over req/ack,
// with byte-lane steering for stores and lane extraction/extension for loads.
module lsu_mem_stage #(
  parameter int MEM_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [31:0]         alu_addr,
  input  logic [31:0]         store_data,
  output logic                busy,
  output logic                done,
  output logic                addr_err,
  output logic [31:0]         load_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack
);

  localparam logic [MEM_OP_W-1:0] OP_LW  = MEM_OP_W'(0);
  localparam logic [MEM_OP_W-1:0] OP_LH  = MEM_OP_W'(1);
  localparam logic [MEM_OP_W-1:0] OP_LHU = MEM_OP_W'(2);
  localparam logic [MEM_OP_W-1:0] OP_LB  = MEM_OP_W'(3);
  localparam logic [MEM_OP_W-1:0] OP_LBU = MEM_OP_W'(4);
  localparam logic [MEM_OP_W-1:0] OP_SW  = MEM_OP_W'(5);
  localparam logic [MEM_OP_W-1:0] OP_SH  = MEM_OP_W'(6);
  localparam logic [MEM_OP_W-1:0] OP_SB  = MEM_OP_W'(7);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t                state_reg, state_next;
  logic [MEM_OP_W-1:0]   op_reg, op_next;
  logic [1:0]            off_reg, off_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  addr_err_reg, addr_err_next;
  logic [31:0]           load_data_reg, load_data_next;
  logic                  mem_req_reg, mem_req_next;
  logic                  mem_we_reg, mem_we_next;
  logic [31:0]           mem_addr_reg, mem_addr_next;
  logic [3:0]            mem_be_reg, mem_be_next;
  logic [31:0]           mem_wdata_reg, mem_wdata_next;

  logic                  is_word, is_half, req_store, misaligned;
  logic [3:0]            be_calc;
  logic [31:0]           wdata_calc;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           rdata_ext;
  logic                  op_is_load;

  // Request-side decode works on the live inputs; results are captured on accept.
  always_comb begin
    is_word    = (mem_op == OP_LW) || (mem_op == OP_SW);
    is_half    = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    req_store  = (mem_op == OP_SW) || (mem_op == OP_SH) || (mem_op == OP_SB);
    misaligned = (is_word && (alu_addr[1:0] != 2'b00)) || (is_half && alu_addr[0]);
    if (is_word)
      be_calc = 4'b1111;
    else if (is_half)
      be_calc = alu_addr[1] ? 4'b1100 : 4'b0011;
    else
      be_calc = 4'b0001 << alu_addr[1:0];
    case (mem_op)
      OP_SW:   wdata_calc = store_data;
      OP_SH:   wdata_calc = {2{store_data[15:0]}};
      OP_SB:   wdata_calc = {4{store_data[7:0]}};
      default: wdata_calc = 32'h0;
    endcase
  end

  // Load-side extraction uses the op/offset latched at accept time.
  always_comb begin
    byte_lane  = mem_rdata[{off_reg, 3'b000} +: 8];
    half_lane  = mem_rdata[{off_reg[1], 4'b0000} +: 16];
    op_is_load = (op_reg == OP_LW) || (op_reg == OP_LH) || (op_reg == OP_LHU) ||
                 (op_reg == OP_LB) || (op_reg == OP_LBU);
    case (op_reg)
      OP_LB:   rdata_ext = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  rdata_ext = {24'h0, byte_lane};
      OP_LH:   rdata_ext = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  rdata_ext = {16'h0, half_lane};
      default: rdata_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    off_next       = off_reg;
    load_data_next = load_data_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_be_next    = mem_be_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next  = mem_op;
          off_next = alu_addr[1:0];
          if (misaligned) begin
            state_next = ERR;
          end else begin
            state_next     = REQ;
            mem_req_next   = 1'b1;
            mem_we_next    = req_store;
            mem_addr_next  = {alu_addr[31:2], 2'b00};
            mem_be_next    = be_calc;
            mem_wdata_next = wdata_calc;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = DONE;
          if (op_is_load)
            load_data_next = rdata_ext;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE) || (state_next == ERR);
    addr_err_next = (state_next == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      off_reg       <= 2'b00;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      addr_err_reg  <= 1'b0;
      load_data_reg <= 32'h0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_be_reg    <= 4'h0;
      mem_wdata_reg <= 32'h0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      off_reg       <= off_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      addr_err_reg  <= addr_err_next;
      load_data_reg <= load_data_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_be_reg    <= mem_be_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign addr_err  = addr_err_reg;
  assign load_data = load_data_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit in the MEM stage, directly downstream of the ALU. It takes the ALU result as the effective address and runs one memory transaction per request over a req/ack handshake to the data memory. It generates word-aligned addresses, byte enables and lane-replicated store data, and extracts and extends load data. It checks alignment and reports errors without touching memory.

Parameters:
MEM_OP_W, 3, width of the mem_op encoding (fixed encoding below; not meant to change)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request strobe from control; sampled only in IDLE
mem_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
alu_addr  input  32  effective address (ALU result)
store_data  input  32  rt value for stores
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
addr_err  output  1  valid with done; 1 = misaligned, no memory access made
load_data  output  32  extended load result; updated only on a successful load's done
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write
mem_addr  output  32  {alu_addr[31:2],2'b00}
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  memory completion; meaningful only while mem_req=1

Behaviour:
- All outputs are registered. Reset: state=IDLE; busy, done, addr_err, mem_req and mem_we = 0; load_data, mem_addr, mem_be and mem_wdata = 0.
- The FSM has four states: IDLE, REQ, DONE and ERR.
- IDLE, start=1: latch mem_op, alu_addr[1:0] and store_data.
  - Misaligned (halfword ops with addr[0]=1; word ops with addr[1:0]!=00): go to ERR.
  - Otherwise go to REQ, with mem_req=1 and mem_addr/mem_be/mem_we/mem_wdata driven from the latched values starting the same edge.
- start while busy is ignored; no queueing.
- REQ: mem_req and the bus outputs are held stable. When mem_ack=1:
  - capture the extracted mem_rdata into load_data (loads only);
  - drop mem_req;
  - go to DONE.
  - Wait states are unbounded.
- DONE: done=1 and addr_err=0 for exactly one cycle, then go to IDLE.
- ERR: done=1 and addr_err=1 for one cycle; mem_req is never asserted; load_data is unchanged. Then go to IDLE.
- Latency with ack in the first REQ cycle:
  - start sampled at edge 0;
  - mem_req high in cycle 1;
  - done high in cycle 2.
  - A new start is accepted in cycle 3 (IDLE).
- Byte enables (off = addr[1:0]):
  - word: 1111;
  - half: 0011 for off=00, 1100 for off=10;
  - byte: 0001 << off.
- Store data:
  - SW passes store_data through;
  - SH replicates {sd[15:0],sd[15:0]};
  - SB replicates the byte {4{sd[7:0]}}.
  - Loads drive mem_we=0 and mem_wdata=0.
- Load extraction:
  - LB/LBU select byte lane off;
  - LH/LHU select halfword lane off[1];
  - LB and LH sign-extend, LBU and LHU zero-extend;
  - LW passes through.
- Stores leave load_data unchanged.
- mem_ack outside REQ is ignored. mem_rdata is sampled only on the ack cycle.
- rst during REQ or DONE returns to IDLE at that edge with all outputs cleared. A late ack afterwards is ignored and no done is produced.

Test Plan:
- LW to 0x00001008, ack after 3 wait cycles, rdata=0xDEADBEEF -> mem_addr=0x00001008, be=1111; mem_req high for 4 cycles; done one cycle later; load_data=0xDEADBEEF, addr_err=0.
- LB at 0x103, then LBU at 0x103, both with zero-wait ack and rdata=0x80112233 -> be=1000 for both; LB load_data=0xFFFFFF80; LBU load_data=0x00000080.
- SH at 0x202 with store_data=0x1234ABCD -> mem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1; load_data unchanged.
- LW at 0x1001 -> ERR: done=1 with addr_err=1 one cycle after start; mem_req stays 0; load_data unchanged.
- start pulsed again while in REQ -> ignored: exactly one transaction and one done pulse.
- rst asserted in the second cycle of REQ, then mem_ack=1 next cycle -> all outputs 0, state IDLE, no done, load_data=0.
